// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if
// Producer-side enqueue handshake for uart_tx_fifo. A word is taken on the clock
// edge where uart_tx_req and uart_tx_ready are both high.
//   uart_tx_data      producer -> fifo  word to enqueue (DATA_BITS wide)
//   uart_tx_req       producer -> fifo  enqueue request
//   uart_tx_ready     fifo -> producer  FIFO not full
//   uart_tx_overflow  fifo -> producer  1-cycle pulse, request seen while full (word dropped)
interface uart_tx_fifo_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic [DATA_BITS-1:0] uart_tx_data;
    logic                 uart_tx_req;
    logic                 uart_tx_ready;
    logic                 uart_tx_overflow;

    modport master (
        output uart_tx_data,
        output uart_tx_req,
        input  uart_tx_ready,
        input  uart_tx_overflow
    );

    modport slave (
        input  uart_tx_data,
        input  uart_tx_req,
        output uart_tx_ready,
        output uart_tx_overflow
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
// UART transmitter with an internal TX FIFO. Words enter through the bus handshake
// and are serialised back-to-back: start bit, DATA_BITS data bits LSB first,
// optional parity bit, STOP_BITS stop bits. Each bit lasts CLK_FREQ/BAUD clocks.
// Ports:
//   clk           system clock
//   rst           synchronous active-high reset, aborts any frame in flight
//   bus           slave side of uart_tx_fifo_if (data, req, ready, overflow)
//   uart_tx       serial line, idle high
//   uart_tx_done  1-cycle pulse on the last clock of each frame's final stop bit
//   uart_tx_busy  a frame is on the line
//   fifo_count    words currently held in the FIFO
module uart_tx_fifo #(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned BAUD       = 115_200,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    uart_tx_fifo_if.slave               bus,
    output logic                        uart_tx,
    output logic                        uart_tx_done,
    output logic                        uart_tx_busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int unsigned BAUD_W       = $clog2(CLKS_PER_BIT);
    localparam int unsigned PTR_W        = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W        = PTR_W + 1;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    // ---------------------------------------------------------------- FIFO
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q;
    logic [PTR_W-1:0]     rd_ptr_q;
    logic [CNT_W-1:0]     count_q;
    logic [CNT_W-1:0]     count_d;
    logic                 ready_q;
    logic                 overflow_q;
    logic                 push;
    logic                 pop;

    // ---------------------------------------------------------------- shifter
    state_e               state_q;
    logic [BAUD_W-1:0]    baud_q;
    logic [2:0]           bit_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 parity_q;
    logic                 tx_q;
    logic                 done_q;
    logic                 busy_q;
    logic                 baud_last;
    logic                 line_bit;
    logic                 head_parity;

    // ready_q is a flop, so a pop in the same cycle can never let a full FIFO accept.
    assign push = bus.uart_tx_req && ready_q;
    assign pop  = (state_q == StIdle) && (count_q != '0);

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push && pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ready_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q    <= count_d;
            ready_q    <= (count_d != CNT_W'(FIFO_DEPTH));
            overflow_q <= bus.uart_tx_req && !ready_q;
        end
    end

    // Storage needs no reset: count_q alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.uart_tx_data;
        end
    end

    // Even parity is the XOR of the data bits; odd parity inverts it.
    assign head_parity = (^mem_q[rd_ptr_q]) ^ (PARITY == 1);
    assign baud_last   = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));

    always_comb begin
        line_bit = 1'b1;
        case (state_q)
            StStart:  line_bit = 1'b0;
            StData:   line_bit = shift_q[0];
            StParity: line_bit = parity_q;
            default:  line_bit = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            parity_q <= 1'b0;
            tx_q     <= 1'b1;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            // Line-side outputs follow the state one clock later, all from flops,
            // so the start bit appears the clock after the pop.
            tx_q   <= line_bit;
            busy_q <= (state_q != StIdle);
            done_q <= (state_q == StStop) && baud_last && (bit_q == 3'(STOP_BITS - 1));

            case (state_q)
                StIdle: begin
                    baud_q <= '0;
                    bit_q  <= '0;
                    if (pop) begin
                        shift_q  <= mem_q[rd_ptr_q];
                        parity_q <= head_parity;
                        state_q  <= StStart;
                    end
                end
                StStart: begin
                    if (baud_last) begin
                        baud_q  <= '0;
                        state_q <= StData;
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
                StData: begin
                    if (baud_last) begin
                        baud_q  <= '0;
                        shift_q <= shift_q >> 1;
                        if (bit_q == 3'(DATA_BITS - 1)) begin
                            bit_q   <= '0;
                            state_q <= (PARITY != 0) ? StParity : StStop;
                        end else begin
                            bit_q <= bit_q + 3'd1;
                        end
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
                StParity: begin
                    if (baud_last) begin
                        baud_q  <= '0;
                        bit_q   <= '0;
                        state_q <= StStop;
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
                StStop: begin
                    if (baud_last) begin
                        baud_q <= '0;
                        if (bit_q == 3'(STOP_BITS - 1)) begin
                            bit_q   <= '0;
                            state_q <= StIdle;
                        end else begin
                            bit_q <= bit_q + 3'd1;
                        end
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.uart_tx_ready    = ready_q;
    assign bus.uart_tx_overflow = overflow_q;
    assign uart_tx              = tx_q;
    assign uart_tx_done         = done_q;
    assign uart_tx_busy         = busy_q;
    assign fifo_count           = count_q;
endmodule
